// File: rtl/wb_pkg.sv
// Shared definitions for the writeback/retire stage: bundle field positions,
// load-size encodings, queue-entry layout and queue occupancy states.
package wb_pkg;

    localparam int WB_BUNDLE_W = 135;

    localparam int B_REGWRITE = 134;
    localparam int B_MEMTOREG = 133;
    localparam int B_LINK     = 132;
    localparam int B_LSIZE_HI = 131;
    localparam int B_LSIZE_LO = 130;
    localparam int B_LSIGNED  = 129;
    localparam int B_RD_HI    = 128;
    localparam int B_RD_LO    = 124;
    localparam int B_ALU_HI   = 123;
    localparam int B_ALU_LO   = 92;
    localparam int B_MEM_HI   = 91;
    localparam int B_MEM_LO   = 60;
    localparam int B_PC4_HI   = 59;
    localparam int B_PC4_LO   = 28;
    localparam int B_RSVD_HI  = 27;

    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10
    } load_size_e;

    typedef struct packed {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } q_state_e;

endpackage

// File: rtl/wb_retire_unit_if.sv
// MEM/WB input handshake, register-file write port and forwarding lookup,
// bundled so the producer/arbiter side and the retire unit share one port.
interface wb_retire_unit_if #(
    parameter int BUNDLE_W = wb_pkg::WB_BUNDLE_W
);
    logic [BUNDLE_W-1:0] in;
    logic                in_valid;
    logic                in_ready;
    logic                rf_we;
    logic [4:0]          rf_waddr;
    logic [31:0]         rf_wdata;
    logic                rf_gnt;
    logic [4:0]          fwd_raddr;
    logic                fwd_hit;
    logic [31:0]         fwd_data;

    modport master (
        output in, in_valid, rf_gnt, fwd_raddr,
        input  in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data
    );

    modport slave (
        input  in, in_valid, rf_gnt, fwd_raddr,
        output in_ready, rf_we, rf_waddr, rf_wdata, fwd_hit, fwd_data
    );
endinterface

// File: rtl/wb_load_align.sv
// Combinational load extraction: picks the byte/half/word addressed by the
// low address bits and sign- or zero-extends it to 32 bits.
module wb_load_align
    import wb_pkg::*;
(
    input  logic [31:0] mem_data,
    input  logic [1:0]  offset,
    input  logic [1:0]  load_size,
    input  logic        load_signed,
    output logic [31:0] data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_data[{offset, 3'b000} +: 8];
        half_sel = mem_data[{offset[1], 4'b0000} +: 16];
        data     = mem_data;
        case (load_size)
            LS_BYTE: data = {{24{load_signed & byte_sel[7]}}, byte_sel};
            LS_HALF: data = {{16{load_signed & half_sel[15]}}, half_sel};
            LS_WORD, 2'b11: data = mem_data;
            default: data = mem_data;
        endcase
    end
endmodule

// File: rtl/wb_retire_unit.sv
// Writeback/retire stage: two-entry pending-write queue draining to the shared
// register-file port, with forwarding search. WB_RETIRE_CNT_EN adds retire_count.
module wb_retire_unit
    import wb_pkg::*;
#(
    parameter int DEPTH    = 2,
    parameter int BUNDLE_W = WB_BUNDLE_W
) (
    input  logic        Clk,
    input  logic        Rst_n,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0] retire_count,
`endif
    wb_retire_unit_if.slave bus
);
    logic [BUNDLE_W-1:0] bundle;
    logic                reg_write;
    logic                mem_to_reg;
    logic                link;
    logic [1:0]          load_size;
    logic                load_signed;
    logic [4:0]          rd;
    logic [31:0]         alu_result;
    logic [31:0]         mem_data;
    logic [31:0]         pc_plus4;
    logic [31:0]         load_data;
    wb_entry_t           new_entry;

    assign bundle      = bus.in;
    assign reg_write   = bundle[B_REGWRITE];
    assign mem_to_reg  = bundle[B_MEMTOREG];
    assign link        = bundle[B_LINK];
    assign load_size   = bundle[B_LSIZE_HI:B_LSIZE_LO];
    assign load_signed = bundle[B_LSIGNED];
    assign rd          = bundle[B_RD_HI:B_RD_LO];
    assign alu_result  = bundle[B_ALU_HI:B_ALU_LO];
    assign mem_data    = bundle[B_MEM_HI:B_MEM_LO];
    assign pc_plus4    = bundle[B_PC4_HI:B_PC4_LO];

    wire unused_reserved = &{1'b0, bundle[B_RSVD_HI:0]};

    wb_load_align u_load_align (
        .mem_data    (mem_data),
        .offset      (alu_result[1:0]),
        .load_size   (load_size),
        .load_signed (load_signed),
        .data        (load_data)
    );

    // Writes to x0 are demoted to no-write entries so they drain without a grant.
    always_comb begin
        new_entry.we   = reg_write && (rd != 5'd0);
        new_entry.rd   = rd;
        new_entry.data = alu_result;
        if (link)
            new_entry.data = pc_plus4;
        else if (mem_to_reg)
            new_entry.data = load_data;
    end

    q_state_e         state_reg;
    q_state_e         state_next;
    wb_entry_t        entry_reg [DEPTH];
    logic [DEPTH-1:0] slot_valid;
    logic             in_ready_int;
    logic             head_valid;
    logic             push;
    logic             pop;

    assign push = bus.in_valid && in_ready_int;
    assign pop  = head_valid && (!entry_reg[0].we || bus.rf_gnt);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state_reg <= EMPTY;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            EMPTY: if (push) state_next = ONE;
            ONE: begin
                if (push && !pop)
                    state_next = FULL;
                else if (pop && !push)
                    state_next = EMPTY;
            end
            FULL:    if (pop) state_next = ONE;
            default: state_next = EMPTY;
        endcase
    end

    // in_ready depends only on occupancy, never on rf_gnt, so a FULL queue
    // refuses input even on the edge its head retires.
    always_comb begin
        slot_valid   = '0;
        in_ready_int = 1'b0;
        head_valid   = 1'b0;
        case (state_reg)
            EMPTY: in_ready_int = Rst_n;
            ONE: begin
                slot_valid   = 2'b01;
                head_valid   = 1'b1;
                in_ready_int = Rst_n;
            end
            FULL: begin
                slot_valid = 2'b11;
                head_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Slot 0 is always the head; slot 1 holds the younger entry when FULL.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                entry_reg[i] <= '0;
        end else begin
            case (state_reg)
                EMPTY: if (push) entry_reg[0] <= new_entry;
                ONE: begin
                    if (push && pop)
                        entry_reg[0] <= new_entry;
                    else if (push)
                        entry_reg[1] <= new_entry;
                end
                FULL:    if (pop) entry_reg[0] <= entry_reg[1];
                default: ;
            endcase
        end
    end

    assign bus.in_ready = in_ready_int;
    assign bus.rf_we    = head_valid && entry_reg[0].we;
    assign bus.rf_waddr = head_valid ? entry_reg[0].rd : 5'd0;
    assign bus.rf_wdata = head_valid ? entry_reg[0].data : 32'd0;

    logic [DEPTH-1:0] fwd_match;
    logic [31:0]      fwd_data_int;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_fwd
            assign fwd_match[gi] = slot_valid[gi] && entry_reg[gi].we &&
                                   (entry_reg[gi].rd == bus.fwd_raddr) &&
                                   (bus.fwd_raddr != 5'd0);
        end
    endgenerate

    // Higher slot index is younger, so later matches overwrite earlier ones.
    always_comb begin
        fwd_data_int = 32'd0;
        for (int i = 0; i < DEPTH; i++)
            if (fwd_match[i])
                fwd_data_int = entry_reg[i].data;
    end

    assign bus.fwd_hit  = |fwd_match;
    assign bus.fwd_data = fwd_data_int;

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_count_reg;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            retire_count_reg <= 32'd0;
        else if (pop)
            retire_count_reg <= retire_count_reg + 32'd1;
    end

    assign retire_count = retire_count_reg;
`endif

endmodule

// File: tb/tb_wb_retire_unit.sv
// Randomized and directed bench for wb_retire_unit against a queue-based
// reference model; define WB_RETIRE_CNT_EN to also cover retire_count.
module tb_wb_retire_unit;

    logic Clk = 1'b0;
    logic Rst_n;

    always #5 Clk = ~Clk;

    wb_retire_unit_if bus ();

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    wb_retire_unit dut (
        .Clk          (Clk),
        .Rst_n        (Rst_n),
`ifdef WB_RETIRE_CNT_EN
        .retire_count (retire_count),
`endif
        .bus          (bus)
    );

    typedef struct {
        bit        we;
        bit [4:0]  rd;
        bit [31:0] data;
    } m_entry_t;

    m_entry_t    mq[$];
    bit [31:0]   exp_cnt;
    int          n_tests = 0;
    int          n_fail  = 0;

    logic        obs_ready;
    logic        obs_we;
    logic [4:0]  obs_waddr;
    logic [31:0] obs_wdata;
    logic        obs_hit;
    logic [31:0] obs_fdata;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [134:0] mk(input bit rw, input bit mtr, input bit lnk,
                                        input bit [1:0] ls, input bit sg, input bit [4:0] rd,
                                        input bit [31:0] alu, input bit [31:0] mem,
                                        input bit [31:0] pc4);
        logic [134:0] b;
        b          = '0;
        b[134]     = rw;
        b[133]     = mtr;
        b[132]     = lnk;
        b[131:130] = ls;
        b[129]     = sg;
        b[128:124] = rd;
        b[123:92]  = alu;
        b[91:60]   = mem;
        b[59:28]   = pc4;
        return b;
    endfunction

    function automatic logic [134:0] alu_bundle(input bit [4:0] rd, input bit [31:0] v);
        return mk(1'b1, 1'b0, 1'b0, 2'd0, 1'b0, rd, v, 32'd0, 32'd0);
    endfunction

    // Writeback value straight from the selection rules, using shifts and masks.
    function automatic bit [31:0] ref_value(input logic [134:0] b);
        bit [31:0] alu;
        bit [31:0] mem;
        bit [31:0] v;
        int        off;
        alu = b[123:92];
        mem = b[91:60];
        off = int'(alu[1:0]);
        if (b[132]) return b[59:28];
        if (!b[133]) return alu;
        if (b[131:130] == 2'd0) begin
            v = (mem >> (8 * off)) & 32'hFF;
            if (b[129] && v[7]) v = v | 32'hFFFF_FF00;
            return v;
        end
        if (b[131:130] == 2'd1) begin
            v = (mem >> (16 * (off / 2))) & 32'hFFFF;
            if (b[129] && v[15]) v = v | 32'hFFFF_0000;
            return v;
        end
        return mem;
    endfunction

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic step(input bit valid, input logic [134:0] b, input bit gnt, input bit [4:0] raddr);
        bit        acc;
        bit        pop;
        bit        hit;
        bit [31:0] fd;
        m_entry_t  e;
        @(negedge Clk);
        bus.in_valid  = valid;
        bus.in        = b;
        bus.rf_gnt    = gnt;
        bus.fwd_raddr = raddr;
        #1;
        obs_ready = bus.in_ready;
        obs_we    = bus.rf_we;
        obs_waddr = bus.rf_waddr;
        obs_wdata = bus.rf_wdata;
        obs_hit   = bus.fwd_hit;
        obs_fdata = bus.fwd_data;

        check_val("in_ready", obs_ready, mq.size() < 2);
        if (mq.size() > 0) begin
            check_val("rf_we", obs_we, mq[0].we);
            check_val("rf_waddr", obs_waddr, mq[0].rd);
            check_val("rf_wdata", obs_wdata, mq[0].data);
        end else begin
            check_val("rf_we_empty", obs_we, 0);
            check_val("rf_waddr_empty", obs_waddr, 0);
            check_val("rf_wdata_empty", obs_wdata, 0);
        end
        hit = 1'b0;
        fd  = 32'd0;
        if (raddr != 5'd0)
            foreach (mq[i])
                if (mq[i].we && mq[i].rd == raddr) begin
                    hit = 1'b1;
                    fd  = mq[i].data;
                end
        check_val("fwd_hit", obs_hit, hit);
        check_val("fwd_data", obs_fdata, fd);
`ifdef WB_RETIRE_CNT_EN
        check_val("retire_count", retire_count, exp_cnt);
`endif
        acc = valid && (mq.size() < 2);
        pop = (mq.size() > 0) && (!mq[0].we || gnt);
        @(posedge Clk);
        if (pop) begin
            $display("[TB] retire #%0d rd=%0d data=0x%08h we=%0d", exp_cnt, mq[0].rd, mq[0].data, mq[0].we);
            void'(mq.pop_front());
            exp_cnt = exp_cnt + 32'd1;
        end
        if (acc) begin
            e.we   = b[134] && (b[128:124] != 5'd0);
            e.rd   = b[128:124];
            e.data = ref_value(b);
            mq.push_back(e);
        end
    endtask

    task automatic drain();
        repeat (3) step(1'b0, '0, 1'b1, 5'd0);
    endtask

    function automatic logic [134:0] rand_bundle();
        logic [134:0] b;
        b = mk($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0,
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               $urandom(), $urandom(), $urandom());
        b[27:0] = 28'($urandom());
        return b;
    endfunction

    initial begin
        exp_cnt       = 32'd0;
        Rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in        = '0;
        bus.rf_gnt    = 1'b0;
        bus.fwd_raddr = 5'd3;

        @(posedge Clk);
        #1;
        check_val("rst_in_ready", bus.in_ready, 0);
        check_val("rst_rf_we", bus.rf_we, 0);
        check_val("rst_rf_waddr", bus.rf_waddr, 0);
        check_val("rst_rf_wdata", bus.rf_wdata, 0);
        check_val("rst_fwd_hit", bus.fwd_hit, 0);
        check_val("rst_fwd_data", bus.fwd_data, 0);
`ifdef WB_RETIRE_CNT_EN
        check_val("rst_retire_count", retire_count, 0);
`endif
        @(negedge Clk);
        Rst_n = 1'b1;

        // Signed byte load at offset 3
        step(1'b1, mk(1, 1, 0, 2'd0, 1, 5'd5, 32'h1003, 32'h80FF_0000, 32'd0), 1'b1, 5'd5);
        step(1'b0, '0, 1'b1, 5'd0);
        check_val("sbyte_we", obs_we, 1);
        check_val("sbyte_waddr", obs_waddr, 5);
        check_val("sbyte_wdata", obs_wdata, 32'hFFFF_FF80);

        // Unsigned half at offset 2, then same bundle with Link
        step(1'b1, mk(1, 1, 0, 2'd1, 0, 5'd6, 32'h0000_0002, 32'hBEEF_1234, 32'h40), 1'b1, 5'd0);
        step(1'b1, mk(1, 1, 1, 2'd1, 0, 5'd6, 32'h0000_0002, 32'hBEEF_1234, 32'h40), 1'b1, 5'd0);
        check_val("uhalf_wdata", obs_wdata, 32'h0000_BEEF);
        step(1'b0, '0, 1'b1, 5'd0);
        check_val("link_wdata", obs_wdata, 32'h40);

        // Backpressure: third bundle held until the head retires
        drain();
        step(1'b1, alu_bundle(5'd1, 32'hA1), 1'b0, 5'd0);
        step(1'b1, alu_bundle(5'd2, 32'hA2), 1'b0, 5'd0);
        step(1'b1, alu_bundle(5'd3, 32'hA3), 1'b0, 5'd0);
        check_val("bp_ready_full", obs_ready, 0);
        step(1'b1, alu_bundle(5'd3, 32'hA3), 1'b1, 5'd0);
        check_val("bp_ready_pop_full", obs_ready, 0);
        check_val("bp_waddr1", obs_waddr, 1);
        step(1'b1, alu_bundle(5'd3, 32'hA3), 1'b1, 5'd0);
        check_val("bp_waddr2", obs_waddr, 2);
        step(1'b0, '0, 1'b1, 5'd0);
        check_val("bp_waddr3", obs_waddr, 3);
        check_val("bp_wdata3", obs_wdata, 32'hA3);

        // Forwarding picks the youngest of two writes to the same register
        drain();
        step(1'b1, alu_bundle(5'd7, 32'h11), 1'b0, 5'd7);
        step(1'b1, alu_bundle(5'd7, 32'h22), 1'b0, 5'd7);
        step(1'b0, '0, 1'b0, 5'd7);
        check_val("fwd_young_hit", obs_hit, 1);
        check_val("fwd_young_data", obs_fdata, 32'h22);
        step(1'b0, '0, 1'b0, 5'd0);
        check_val("fwd_x0_hit", obs_hit, 0);
        drain();

        // No-write bundles retire without a grant and never raise rf_we
        step(1'b1, mk(0, 0, 0, 2'd0, 0, 5'd4, 32'h55, 32'd0, 32'd0), 1'b0, 5'd4);
        step(1'b0, '0, 1'b0, 5'd4);
        check_val("nowr_we", obs_we, 0);
        check_val("nowr_fwd", obs_hit, 0);
        step(1'b1, alu_bundle(5'd0, 32'h66), 1'b0, 5'd0);
        check_val("nowr_ready", obs_ready, 1);
        step(1'b0, '0, 1'b0, 5'd0);
        check_val("rd0_we", obs_we, 0);
        step(1'b0, '0, 1'b0, 5'd0);
        check_val("rd0_drained", obs_waddr, 0);

        // Reset with the queue full
        step(1'b1, alu_bundle(5'd9, 32'h99), 1'b0, 5'd9);
        step(1'b1, alu_bundle(5'd10, 32'h9A), 1'b0, 5'd9);
        @(negedge Clk);
        bus.in_valid = 1'b0;
        bus.rf_gnt   = 1'b1;
        #2;
        Rst_n = 1'b0;
        #1;
        check_val("mrst_rf_we", bus.rf_we, 0);
        check_val("mrst_in_ready", bus.in_ready, 0);
        check_val("mrst_fwd_hit", bus.fwd_hit, 0);
        mq.delete();
        exp_cnt = 32'd0;
        @(negedge Clk);
        Rst_n = 1'b1;
        step(1'b0, '0, 1'b1, 5'd9);
        check_val("mrst_ready_after", obs_ready, 1);
        check_val("mrst_no_stale", obs_we, 0);
        step(1'b0, '0, 1'b1, 5'd10);

`ifdef WB_RETIRE_CNT_EN
        repeat (5) step(1'b1, alu_bundle(5'd2, 32'h5), 1'b1, 5'd0);
        step(1'b0, '0, 1'b1, 5'd0);
        check_val("cnt_five", retire_count, 5);
        #1;
        force dut.retire_count_reg = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count_reg;
        exp_cnt = 32'hFFFF_FFFF;
        step(1'b1, alu_bundle(5'd1, 32'h1), 1'b1, 5'd0);
        step(1'b0, '0, 1'b1, 5'd0);
        step(1'b0, '0, 1'b1, 5'd0);
        check_val("cnt_wrap", retire_count, 0);
`endif

        // Randomized traffic
        repeat (400)
            step($urandom_range(0, 3) != 0, rand_bundle(), $urandom_range(0, 9) < 6,
                 5'($urandom_range(0, 7)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
